// File: rtl/chess_pkg.sv
// Shared chess encodings: piece/color constants, controller state encoding,
// and the standard starting-position lookup used by the board controller.
package chess_pkg;

   localparam logic [2:0] PT_EMPTY  = 3'b000;
   localparam logic [2:0] PT_PAWN   = 3'b001;
   localparam logic [2:0] PT_BISHOP = 3'b010;
   localparam logic [2:0] PT_KNIGHT = 3'b011;
   localparam logic [2:0] PT_ROOK   = 3'b100;
   localparam logic [2:0] PT_QUEEN  = 3'b101;
   localparam logic [2:0] PT_KING   = 3'b110;

   localparam logic COLOR_WHITE = 1'b0;
   localparam logic COLOR_BLACK = 1'b1;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int NUM_SQUARES = 64;

   typedef struct packed {
      logic       color;
      logic [2:0] ptype;
   } piece_t;

   // An empty square is canonically all-zero regardless of the color bit.
   function automatic logic [3:0] make_piece(input logic color, input logic [2:0] ptype);
      piece_t p;
      p.color = (ptype == PT_EMPTY) ? 1'b0 : color;
      p.ptype = ptype;
      return p;
   endfunction

   function automatic logic [2:0] back_rank_type(input logic [2:0] col);
      logic [2:0] t;
      case (col)
         3'd0, 3'd7: t = PT_ROOK;
         3'd1, 3'd6: t = PT_KNIGHT;
         3'd2, 3'd5: t = PT_BISHOP;
         3'd3:       t = PT_QUEEN;
         default:    t = PT_KING;
      endcase
      return t;
   endfunction

   // Row 0 is the top of the board (black side).
   function automatic logic [3:0] init_piece(input logic [5:0] addr);
      logic [2:0] row;
      logic [2:0] col;
      logic [3:0] p;
      row = addr[5:3];
      col = addr[2:0];
      case (row)
         3'd0:    p = make_piece(COLOR_BLACK, back_rank_type(col));
         3'd1:    p = make_piece(COLOR_BLACK, PT_PAWN);
         3'd6:    p = make_piece(COLOR_WHITE, PT_PAWN);
         3'd7:    p = make_piece(COLOR_WHITE, back_rank_type(col));
         default: p = make_piece(COLOR_WHITE, PT_EMPTY);
      endcase
      return p;
   endfunction

endpackage

// File: rtl/chess_init_rom.sv
// Combinational starting-position lookup: square address in, piece code out.
module chess_init_rom
   import chess_pkg::*;
(
   input  logic [5:0] addr_i,
   output logic [3:0] piece_o
);

   always_comb begin
      piece_o = init_piece(addr_i);
   end

endmodule

// File: rtl/board_controller.sv
// Owns the 64-square board: sweeps in the starting position after reset or
// new_game, otherwise applies single-square writes from the game logic.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping starting position, one square per cycle; busy=1
// ST_RUN  | accepting wr_en writes with 1-cycle latency
module board_controller
   import chess_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         new_game,
   input  logic         wr_en,
   input  logic [5:0]   wr_address,
   input  logic [3:0]   wr_piece,
   output logic [255:0] passed_board,
   output logic         busy,
   output logic         init_done,
   output logic         wr_rejected
);

   logic [0:0] state_q, state_d;
   logic [5:0] sweep_addr_q, sweep_addr_d;
   logic       busy_q, busy_d;
   logic       init_done_q, init_done_d;
   logic       wr_rejected_q, wr_rejected_d;

   logic       brd_we;
   logic [5:0] brd_addr;
   logic [3:0] brd_data;
   logic [3:0] rom_piece;

   chess_init_rom u_init_rom (
      .addr_i  (sweep_addr_q),
      .piece_o (rom_piece)
   );

   // new_game outranks the sweep, which outranks game-logic writes.
   always_comb begin
      state_d       = state_q;
      sweep_addr_d  = sweep_addr_q;
      busy_d        = busy_q;
      init_done_d   = 1'b0;
      wr_rejected_d = wr_en & (new_game | (state_q == ST_INIT));
      brd_we        = 1'b0;
      brd_addr      = sweep_addr_q;
      brd_data      = rom_piece;

      if (new_game) begin
         state_d      = ST_INIT;
         sweep_addr_d = 6'd0;
         busy_d       = 1'b1;
      end else begin
         case (state_q)
            ST_INIT: begin
               brd_we       = 1'b1;
               sweep_addr_d = sweep_addr_q + 6'd1;
               if (&sweep_addr_q) begin
                  state_d     = ST_RUN;
                  busy_d      = 1'b0;
                  init_done_d = 1'b1;
               end
            end
            default: begin
               if (wr_en) begin
                  brd_we   = 1'b1;
                  brd_addr = wr_address;
                  brd_data = make_piece(wr_piece[3], wr_piece[2:0]);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_INIT;
         sweep_addr_q  <= 6'd0;
         busy_q        <= 1'b1;
         init_done_q   <= 1'b0;
         wr_rejected_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sweep_addr_q  <= sweep_addr_d;
         busy_q        <= busy_d;
         init_done_q   <= init_done_d;
         wr_rejected_q <= wr_rejected_d;
      end
   end

   for (genvar n = 0; n < NUM_SQUARES; n++) begin : g_sq
      logic [3:0] sq_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            sq_q <= 4'b0000;
         end else if (brd_we && (brd_addr == 6'(n))) begin
            sq_q <= brd_data;
         end
      end

      assign passed_board[4*n +: 4] = sq_q;
   end

   assign busy        = busy_q;
   assign init_done   = init_done_q;
   assign wr_rejected = wr_rejected_q;

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: sweep timing, RUN writes, drops and restarts.
module tb_board_controller;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         new_game = 1'b0;
   logic         wr_en = 1'b0;
   logic [5:0]   wr_address = 6'd0;
   logic [3:0]   wr_piece = 4'd0;
   logic [255:0] passed_board;
   logic         busy;
   logic         init_done;
   logic         wr_rejected;

   int checks = 0;
   int failures = 0;

   board_controller dut (
      .clk          (clk),
      .rst          (rst),
      .new_game     (new_game),
      .wr_en        (wr_en),
      .wr_address   (wr_address),
      .wr_piece     (wr_piece),
      .passed_board (passed_board),
      .busy         (busy),
      .init_done    (init_done),
      .wr_rejected  (wr_rejected)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] sq(input int n);
      return passed_board[4*n +: 4];
   endfunction

   // Hand-written starting position, row 0 = black back rank.
   function automatic logic [255:0] start_board();
      logic [255:0] b;
      logic [3:0]   back [8];
      back[0] = 4'hC; back[1] = 4'hB; back[2] = 4'hA; back[3] = 4'hD;
      back[4] = 4'hE; back[5] = 4'hA; back[6] = 4'hB; back[7] = 4'hC;
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[4*(0*8+c) +: 4] = back[c];
         b[4*(1*8+c) +: 4] = 4'h9;
         b[4*(6*8+c) +: 4] = 4'h1;
         b[4*(7*8+c) +: 4] = back[c] & 4'h7;
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge following sweep edge start_edge; waits for init_done.
   task automatic run_sweep(input int start_edge, input string tag);
      int n;
      logic busy_ok;
      n = start_edge;
      busy_ok = 1'b1;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (init_done === 1'b1) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      chk({tag, "_done_edge"}, 256'(n), 256'd64);
      chk({tag, "_busy_held"}, 256'(busy_ok), 256'd1);
      chk({tag, "_busy_low"}, 256'(busy), 256'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 256'(init_done), 256'd0);
   endtask

   task automatic write_sq(input logic [5:0] a, input logic [3:0] p);
      wr_en = 1'b1; wr_address = a; wr_piece = p;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      // Reset sweep
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_board", passed_board, 256'd0);
      chk("rst_busy", 256'(busy), 256'd1);
      chk("rst_done", 256'(init_done), 256'd0);
      chk("rst_rej", 256'(wr_rejected), 256'd0);
      run_sweep(0, "reset_sweep");
      chk("sq0", 256'(sq(0)), 256'hC);
      chk("sq4", 256'(sq(4)), 256'hE);
      chk("sq8", 256'(sq(8)), 256'h9);
      chk("sq52", 256'(sq(52)), 256'h1);
      chk("sq60", 256'(sq(60)), 256'h6);
      chk("sq32", 256'(sq(32)), 256'h0);
      chk("start_full", passed_board, start_board());

      // RUN writes
      write_sq(6'd36, 4'b0001);
      chk("w36", 256'(sq(36)), 256'h1);
      chk("w36_rej", 256'(wr_rejected), 256'd0);
      write_sq(6'd52, 4'b0000);
      chk("w52", 256'(sq(52)), 256'h0);
      chk("w52_rej", 256'(wr_rejected), 256'd0);
      wr_en = 1'b1; wr_address = 6'd10; wr_piece = 4'b0101;
      @(negedge clk);
      chk("w10_first", 256'(sq(10)), 256'h5);
      wr_piece = 4'b0110;
      @(negedge clk);
      wr_en = 1'b0;
      chk("w10_last", 256'(sq(10)), 256'h6);
      write_sq(6'd11, 4'b1000);
      chk("w11_empty_norm", 256'(sq(11)), 256'h0);

      // Write during INIT
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      chk("ng_busy", 256'(busy), 256'd1);
      chk("ng_rej", 256'(wr_rejected), 256'd0);
      repeat (9) @(negedge clk);
      write_sq(6'd40, 4'b0101);
      chk("init_wr_rej", 256'(wr_rejected), 256'd1);
      @(negedge clk);
      chk("init_wr_rej_pulse", 256'(wr_rejected), 256'd0);
      run_sweep(11, "init_wr_sweep");
      chk("sq40_after", 256'(sq(40)), 256'h0);
      chk("restored_full", passed_board, start_board());

      // Simultaneous new_game and wr_en in RUN
      new_game = 1'b1; wr_en = 1'b1; wr_address = 6'd20; wr_piece = 4'b0101;
      @(negedge clk);
      new_game = 1'b0; wr_en = 1'b0;
      chk("ngwr_rej", 256'(wr_rejected), 256'd1);
      chk("ngwr_busy", 256'(busy), 256'd1);
      chk("ngwr_sq20_now", 256'(sq(20)), 256'h0);
      run_sweep(0, "ngwr_sweep");
      chk("ngwr_sq20", 256'(sq(20)), 256'h0);

      // new_game mid-sweep
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      repeat (29) @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      chk("restart_busy", 256'(busy), 256'd1);
      run_sweep(0, "restart_sweep");
      chk("restart_full", passed_board, start_board());

      // rst mid-RUN
      write_sq(6'd0, 4'b0000);
      write_sq(6'd44, 4'b0011);
      chk("mod_sq0", 256'(sq(0)), 256'h0);
      chk("mod_sq44", 256'(sq(44)), 256'h3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstrun_board", passed_board, 256'd0);
      chk("rstrun_busy", 256'(busy), 256'd1);
      run_sweep(0, "rstrun_sweep");
      chk("rstrun_full", passed_board, start_board());

      // rst mid-sweep
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstsweep_board", passed_board, 256'd0);
      run_sweep(0, "rstsweep_sweep");
      chk("rstsweep_full", passed_board, start_board());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/board_controller.md
# board_controller

Owns the 64-square chess board storage and sequences all writes into it. After reset, or on a new-game request, it sweeps all 64 squares one per cycle to load the standard starting position. Otherwise it accepts single-square write requests from the game-logic block. It drives the flattened 256-bit board that the game logic and the VGA renderer read, and flags writes it drops while busy.

## Interface
- No parameters; board geometry (8x8, 4-bit squares) is fixed.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- new_game  in  1  level-sampled request to reload the starting position
- wr_en  in  1  write request from game logic
- wr_address  in  6  target square; row = [5:3] (0 = top), col = [2:0]
- wr_piece  in  4  {color, type}; color WHITE=0, BLACK=1
- passed_board  out  256  square n at bits [4n+3:4n]
- busy  out  1  high while the init sweep is running
- init_done  out  1  one-cycle pulse when a sweep completes
- wr_rejected  out  1  one-cycle pulse: a wr_en was dropped

## Operation
- Piece types: EMPTY=000, PAWN=001, BISHOP=010, KNIGHT=011, ROOK=100, QUEEN=101, KING=110. An empty square is always stored as 4'b0000.
- Starting position:
  - row 0: black back rank, cols 0..7 = R N B Q K B N R, i.e. 1100 1011 1010 1101 1110 1010 1011 1100.
  - row 1: black pawns, 1001.
  - rows 2-5: 0000.
  - row 6: white pawns, 0001.
  - row 7: white back rank, same order with color 0.
- States:
  - INIT: each cycle writes init_piece(sweep_addr) into board[sweep_addr], then increments sweep_addr (6-bit). The write to addr 63 also moves to RUN.
  - RUN: if wr_en=1 and new_game=0, writes wr_piece into board[wr_address]. If new_game=1, goes to INIT with sweep_addr=0.
- Priority, highest first: rst, then new_game, then the sweep, then wr_en.
- wr_en in INIT, or with new_game=1 in RUN: the write is dropped and wr_rejected=1 on the next cycle.
- new_game during INIT restarts the sweep at addr 0. It is not queued.
- Repeated writes to the same square in consecutive cycles are all applied; the last one wins.
- The sweep does not clear the board first. Squares not yet swept keep their old contents while busy=1.
- Consumers must treat passed_board as invalid while busy=1.

## Timing
- Reset values: passed_board=0, busy=1, init_done=0, wr_rejected=0, state=INIT, sweep_addr=0.
- Writes (RUN):
  - A write sampled at edge k appears on passed_board after edge k.
  - Write latency is 1 cycle and there is no back-pressure in RUN.
- Sweep:
  - Counting from the edge where the sweep starts (rst or new_game sampled) as edge 0, edges 1..64 write squares 0..63.
  - After edge 64: busy=0, init_done=1 for exactly one cycle, state=RUN.
  - Total sweep length is 64 cycles.
- busy goes high one cycle after the new_game edge. All outputs are registered.
- rst mid-sweep or mid-RUN: the next cycle matches the reset values, board cleared to 0.

## Structure
- Shared package chess_pkg holds:
  - the piece-type and color constants;
  - the state encoding (INIT, RUN);
  - function init_piece(addr[5:0]) returning 4 bits.
- Game logic and the renderer import the same package.
- One sub-module, chess_init_rom: a combinational 6-bit-address to 4-bit-piece lookup that implements init_piece. The controller instantiates it with sweep_addr.
- Board storage is 64 four-bit registers, flattened onto passed_board with a generate loop.

## Test plan
- **Reset sweep.** Pulse rst, then run 64 cycles.
  - busy=1 for cycles 1..64, init_done pulses once at cycle 65.
  - passed_board[3:0]=1100, [19:16]=1110, square 8=1001, square 52=0001, square 60=0110, square 32=0000.
- **RUN writes.**
  - wr_en with addr 36, piece 0001: square 36=0001 the next cycle.
  - Then addr 52, piece 0000: square 52=0000, wr_rejected stays 0.
- **Write during INIT.** wr_en at sweep cycle 10 with addr 40, piece 0101:
  - wr_rejected=1 for one cycle;
  - square 40=0000 after the sweep completes.
- **Simultaneous new_game and wr_en in RUN.** addr 20, piece 0101:
  - write dropped, wr_rejected=1, busy=1 the next cycle;
  - square 20=0000 after 64 cycles.
- **new_game mid-sweep.** Assert new_game at sweep cycle 30:
  - sweep restarts at 0;
  - init_done fires 64 cycles after the restart, not at the original completion time.
- **rst mid-RUN.** Modify squares first, then assert rst for one cycle:
  - passed_board=0, busy=1 the next cycle;
  - full starting position 64 cycles later.
